// File: rtl/cart_arb_pkg.sv
// Shared types and constants for the cartridge SDRAM port arbiter.
package cart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    LD_ACC
  } arb_state_e;

  typedef enum logic {
    GRANT_CPU,
    GRANT_LD
  } grant_e;

  localparam logic [7:0] CPU_DOUT_RST = 8'hFF;

endpackage

// File: rtl/cart_wbuf.sv
// One-entry holding register for ROM-download writes; full doubles as ioctl_wait.
module cart_wbuf #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              complete,
  output logic              accept,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // A write arriving while full is a loader protocol violation and is dropped.
  assign accept = wr & ~full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (accept) begin
      full <= 1'b1;
      addr <= wr_addr;
      data <= wr_data;
    end else if (complete) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge SDRAM request port between T80 reads and ioctl loader
// writes, with a one-entry CPU read cache and strict alternation under contention.
module cart_mem_arbiter
  import cart_arb_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_wait_n,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ack
);

  arb_state_e        state, state_n;
  grant_e            last_grant;
  logic              cpu_pend, rd_stale, cache_valid;
  logic [ADDR_W-1:0] rd_addr, cache_addr;
  logic [DATA_W-1:0] cache_data;
  logic              wb_accept, wb_full;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              cpu_hit, cpu_miss;
  logic              start_cpu, start_ld, cpu_done, ld_done;

  cart_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .wr       (ioctl_wr),
    .wr_addr  (ioctl_addr),
    .wr_data  (ioctl_dout),
    .complete (ld_done),
    .accept   (wb_accept),
    .full     (wb_full),
    .addr     (wb_addr),
    .data     (wb_data)
  );

  assign ioctl_wait = wb_full;
  assign cpu_wait_n = ~cpu_pend;

  assign cpu_hit  = cpu_rd & ~cpu_pend & cache_valid & (cpu_addr == cache_addr);
  assign cpu_miss = cpu_rd & ~cpu_pend & ~cpu_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_cpu = 1'b0;
    start_ld  = 1'b0;
    cpu_done  = 1'b0;
    ld_done   = 1'b0;
    case (state)
      IDLE: begin
        // Under contention the requester that was not served last wins.
        if (cpu_pend && (!wb_full || last_grant == GRANT_LD)) begin
          state_n   = CPU_ACC;
          start_cpu = 1'b1;
        end else if (wb_full) begin
          state_n  = LD_ACC;
          start_ld = 1'b1;
        end
      end
      CPU_ACC: begin
        if (mem_ack) begin
          state_n  = IDLE;
          cpu_done = 1'b1;
        end
      end
      LD_ACC: begin
        if (mem_ack) begin
          state_n = IDLE;
          ld_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (start_cpu) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= rd_addr;
    end else if (start_ld) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b1;
      mem_addr <= wb_addr;
      mem_din  <= wb_data;
    end else if (cpu_done || ld_done) begin
      mem_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_pend   <= 1'b0;
      cpu_dout   <= DATA_W'(CPU_DOUT_RST);
      rd_addr    <= '0;
      last_grant <= GRANT_LD;
    end else begin
      if (cpu_hit) cpu_dout <= cache_data;
      if (cpu_miss) begin
        cpu_pend <= 1'b1;
        rd_addr  <= cpu_addr;
      end
      if (cpu_done) begin
        cpu_dout   <= mem_dout;
        cpu_pend   <= 1'b0;
        last_grant <= GRANT_CPU;
      end
      if (ld_done) last_grant <= GRANT_LD;
    end
  end

  // A loader write landing from miss capture until read completion may
  // overwrite what the read fetched, so that read must not populate the cache.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_stale    <= 1'b0;
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
    end else begin
      if (cpu_done)                            rd_stale <= 1'b0;
      else if (wb_accept && (cpu_pend || cpu_miss)) rd_stale <= 1'b1;

      if (wb_accept)                  cache_valid <= 1'b0;
      else if (cpu_done && !rd_stale) cache_valid <= 1'b1;

      if (cpu_done) begin
        cache_addr <= rd_addr;
        cache_data <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Randomized + directed bench for cart_mem_arbiter against an SDRAM model and memory shadow.
module tb_cart_mem_arbiter;

  localparam int L   = 3;   // directed-test memory latency (req cycle to ack cycle)
  localparam int RLB = 13;  // worst read wait: one loader access plus own, max latency 4

  typedef struct packed {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, ioctl_wr, mem_ack;
  logic [24:0] cpu_addr, ioctl_addr;
  logic [7:0]  ioctl_dout, mem_dout;
  logic [7:0]  cpu_dout;
  logic        cpu_wait_n, ioctl_wait, mem_req, mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;

  int   n_chk = 0, n_ok = 0;
  int   lat_fix, n_wr;
  bit   mdl_en;
  acc_t acc[$];
  logic [7:0] mem [logic [24:0]];

  cart_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_wait_n (cpu_wait_n),
    .ioctl_wr   (ioctl_wr),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .ioctl_wait (ioctl_wait),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] mrd(input logic [24:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5C;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(cpu_wait_n && !ioctl_wait && !mem_req) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, n < 200, 1);
  endtask

  // SDRAM model: one request at a time, ack lat cycles after req is seen.
  initial begin
    bit   busy = 0, acked = 0;
    int   cnt = 0;
    acc_t cur;
    forever begin
      @(posedge clk);
      #1;
      if (mdl_en) begin
        mem_ack = 1'b0;
        if (reset) begin
          busy  = 0;
          acked = 0;
        end else begin
          if (acked) begin
            chk("req_gap", mem_req, 0);
            acked = 0;
            busy  = 0;
          end
          if (busy) begin
            chk("req_hold", {mem_req, mem_we, mem_addr, mem_din}, {1'b1, cur});
            cnt--;
            if (cnt == 0) begin
              mem_ack = 1'b1;
              if (cur.we) begin
                mem[cur.addr] = cur.din;
                n_wr++;
              end else begin
                mem_dout = mrd(cur.addr);
              end
              acked = 1;
            end
          end else if (mem_req) begin
            busy = 1;
            cur  = '{we: mem_we, addr: mem_addr, din: mem_din};
            cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
            acc.push_back(cur);
          end
        end
      end
    end
  end

  task automatic rd(input logic [24:0] a);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    tick();
    cpu_rd   = 1'b0;
  endtask

  task automatic ld(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    logic [7:0] old_v;
    logic [7:0] expw [16];
    bit         wrote [16];
    bit         rd_wait = 0, rd_just = 0;
    int         rd_cyc = 0, n_rd = 0, n_done = 0, n_wexp = 0;
    logic [24:0] rd_a = '0;

    reset = 1'b1; cpu_rd = 0; ioctl_wr = 0; mem_ack = 0; mem_dout = 0;
    cpu_addr = 0; ioctl_addr = 0; ioctl_dout = 0;
    mdl_en = 1; lat_fix = L; n_wr = 0;
    mem[25'h100] = 8'h5A;
    for (int k = 0; k < 16; k++) wrote[k] = 0;
    repeat (3) tick();

    chk("rst_waitn", cpu_wait_n, 1);
    chk("rst_dout", cpu_dout, 8'hFF);
    chk("rst_iwait", ioctl_wait, 0);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_din}, 0);
    reset = 1'b0;
    tick();

    // Miss with idle port, then hit on the same address.
    rd(25'h100);
    for (int c = 1; c <= 3 + L; c++) begin
      chk("t1_waitn", cpu_wait_n, c == 3 + L);
      chk("t1_req", mem_req, c >= 2 && c <= 2 + L);
      if (c == 3 + L) chk("t1_dout", cpu_dout, 8'h5A);
      tick();
    end
    chk("t1_nacc", acc.size(), 1);
    if (acc.size() == 1) chk("t1_acc", {acc[0].we, acc[0].addr}, {1'b0, 25'h100});
    mem[25'h100] = 8'h11;
    rd(25'h100);
    chk("t1_hit_waitn", cpu_wait_n, 1);
    chk("t1_hit_dout", cpu_dout, 8'h5A);
    repeat (4) begin
      chk("t1_hit_noreq", mem_req, 0);
      tick();
    end

    // Loader write invalidates the cache and goes first.
    acc.delete();
    ld(25'h100, 8'hA5);
    chk("t2_iwait1", ioctl_wait, 1);
    rd(25'h100);
    for (int c = 2; c <= 5 + 2 * L; c++) begin
      chk("t2_iwait", ioctl_wait, c < 3 + L);
      chk("t2_waitn", cpu_wait_n, c >= 5 + 2 * L);
      if (c == 5 + 2 * L) chk("t2_dout", cpu_dout, 8'hA5);
      tick();
    end
    chk("t2_nacc", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("t2_wr", acc[0], {1'b1, 25'h100, 8'hA5});
      chk("t2_rd", {acc[1].we, acc[1].addr}, {1'b0, 25'h100});
    end

    // Simultaneous requests after a loader grant: CPU first.
    ld(25'h300, 8'h77);
    wait_idle("t3a_pre");
    acc.delete();
    cpu_addr = 25'h301; cpu_rd = 1;
    ioctl_addr = 25'h302; ioctl_dout = 8'h33; ioctl_wr = 1;
    tick();
    cpu_rd = 0; ioctl_wr = 0;
    wait_idle("t3a_done");
    chk("t3a_nacc", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("t3a_first", {acc[0].we, acc[0].addr}, {1'b0, 25'h301});
      chk("t3a_second", acc[1], {1'b1, 25'h302, 8'h33});
    end
    chk("t3a_dout", cpu_dout, mrd(25'h301));

    // Simultaneous requests after a CPU grant: loader first.
    rd(25'h303);
    wait_idle("t3b_pre");
    acc.delete();
    cpu_addr = 25'h304; cpu_rd = 1;
    ioctl_addr = 25'h305; ioctl_dout = 8'h44; ioctl_wr = 1;
    tick();
    cpu_rd = 0; ioctl_wr = 0;
    wait_idle("t3b_done");
    chk("t3b_nacc", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("t3b_first", acc[0], {1'b1, 25'h305, 8'h44});
      chk("t3b_second", {acc[1].we, acc[1].addr}, {1'b0, 25'h304});
    end
    chk("t3b_dout", cpu_dout, mrd(25'h304));

    // Loader write to the address of an outstanding read.
    old_v = mrd(25'h310);
    rd(25'h310);
    tick();
    chk("t5_req", mem_req, 1);
    ld(25'h310, 8'hC3);
    wait_idle("t5_done");
    chk("t5_old", cpu_dout, old_v);
    rd(25'h310);
    tick();
    chk("t5_miss", mem_req, 1);
    wait_idle("t5_done2");
    chk("t5_new", cpu_dout, 8'hC3);

    // Reset during a CPU access with a loader write buffered.
    rd(25'h320);
    ld(25'h321, 8'h99);
    chk("t6_req", mem_req, 1);
    chk("t6_iwait", ioctl_wait, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_waitn", cpu_wait_n, 1);
    chk("t6_rst_iwait", ioctl_wait, 0);
    chk("t6_rst_dout", cpu_dout, 8'hFF);
    tick();
    reset = 1'b0;
    mdl_en = 0;
    mem_ack = 1'b1; mem_dout = 8'hEE;
    tick();
    mem_ack = 1'b0;
    repeat (4) begin
      chk("t6_idle_req", mem_req, 0);
      chk("t6_idle_waitn", cpu_wait_n, 1);
      tick();
    end
    chk("t6_idle_dout", cpu_dout, 8'hFF);
    mdl_en = 1;

    // Random loader stream with interleaved CPU reads and random latency.
    lat_fix = 0; n_wr = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rd_just) begin
        if (cpu_wait_n) begin
          chk("rnd_hit", cpu_dout, mrd(rd_a));
          n_done++;
        end else rd_wait = 1;
        rd_just = 0;
      end else if (rd_wait && cpu_wait_n) begin
        chk("rnd_miss", cpu_dout, mrd(rd_a));
        chk("rnd_lat", (i - rd_cyc) <= RLB, 1);
        rd_wait = 0;
        n_done++;
      end
      cpu_rd = 0; ioctl_wr = 0;
      if (i < 1480) begin
        if (!ioctl_wait && $urandom_range(0, 2) == 0) begin
          automatic int k = int'($urandom_range(0, 15));
          ioctl_addr = 25'h200 + 25'(k);
          ioctl_dout = 8'($urandom);
          ioctl_wr   = 1;
          expw[k]    = ioctl_dout;
          wrote[k]   = 1;
          n_wexp++;
        end
        if (cpu_wait_n && !rd_wait && $urandom_range(0, 1) == 0) begin
          rd_a     = 25'h200 + 25'($urandom_range(0, 15));
          cpu_addr = rd_a;
          cpu_rd   = 1;
          rd_cyc   = i;
          rd_just  = 1;
          n_rd++;
        end
      end
      tick();
    end
    cpu_rd = 0; ioctl_wr = 0;
    wait_idle("rnd_drain");
    chk("rnd_nrd", n_done, n_rd);
    chk("rnd_nwr", n_wr, n_wexp);
    for (int k = 0; k < 16; k++)
      if (wrote[k]) chk("rnd_mem", mrd(25'h200 + 25'(k)), expw[k]);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
